q_learn_seq_ctrl: RTL

//  Sequencer for one Q-learning agent on the 6x6 maze (states 0..35, 4 actions).

---
 rtl/q_learn_pkg.sv | 53 +++++
 rtl/q_learn_seq_ctrl_q_row_max.sv | 50 +++++
 rtl/q_learn_seq_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/q_learn_pkg.sv
// Shared types and maze geometry for the Q-learning sequencer.
// Grid moves are resolved here so the controller only sees state_t.
package q_learn_pkg;

  localparam int GRID_W    = 6;
  localparam int N_STATES  = 36;
  localparam int N_ACTIONS = 4;

  typedef logic [5:0] state_t;
  typedef logic signed [15:0] q_t;

  typedef enum logic [1:0] {
    ACT_DOWN,
    ACT_RIGHT,
    ACT_UP,
    ACT_LEFT
  } action_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CUR,
    S_SEL,
    S_MOVE,
    S_RD_NXT,
    S_UPD,
    S_CHK
  } fsm_state_t;

  // Off-grid moves leave the agent where it is.
  function automatic state_t step_state(
    input state_t  s,
    input action_t a
  );
    state_t col;
    col = state_t'(s % state_t'(GRID_W));
    step_state = s;
    unique case (a)
      ACT_DOWN:
        if (s < state_t'(N_STATES - GRID_W))
          step_state = s + state_t'(GRID_W);
      ACT_RIGHT:
        if (col != state_t'(GRID_W - 1))
          step_state = s + 6'd1;
      ACT_UP:
        if (s >= state_t'(GRID_W))
          step_state = s - state_t'(GRID_W);
      ACT_LEFT:
        if (col != 6'd0)
          step_state = s - 6'd1;
    endcase
  endfunction

endpackage

// File: rtl/q_learn_seq_ctrl_q_row_max.sv
// Streamed argmax over one Q-table row (4 values, ties keep lowest index).
// Outputs already include the value presented this cycle.
module q_row_max
  import q_learn_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    clear,
  input  logic    valid,
  input  q_t      value,
  output q_t      max_val,
  output action_t max_idx,
  output q_t      vals [N_ACTIONS]
);

  logic [1:0] cnt_q;
  q_t         max_q;
  action_t    idx_q;
  q_t         vals_q [N_ACTIONS];
  logic       take;

  assign take = valid
    && (cnt_q == 2'd0 || value > max_q);

  always_comb begin
    max_val = take ? value : max_q;
    max_idx = take ? action_t'(cnt_q) : idx_q;
    vals    = vals_q;
    if (valid)
      vals[cnt_q] = value;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      max_q <= '0;
      idx_q <= ACT_DOWN;
      for (int i = 0; i < N_ACTIONS; i++)
        vals_q[i] <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (valid) begin
      cnt_q         <= cnt_q + 2'd1;
      max_q         <= max_val;
      idx_q         <= max_idx;
      vals_q[cnt_q] <= value;
    end
  end

endmodule

// File: rtl/q_learn_seq_ctrl.sv
// Q-learning episode sequencer driving a 1R/1W Q-table RAM.
// Define EPSILON_GREEDY_EN for LFSR-based epsilon-greedy exploration.
module q_learn_seq_ctrl
  import q_learn_pkg::*;
#(
  parameter int                 ALPHA_SHIFT = 2,
  parameter int                 GAMMA_SHIFT = 3,
  parameter logic signed [15:0] REWARD      = 16'sh0A00,
  parameter int                 START_STATE = 0,
  parameter int                 GOAL_STATE  = 35,
  parameter int                 MAX_STEPS   = 64
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_episodes,
  output logic        busy,
  output logic        done,
  output logic        q_rd_en,
  output logic [7:0]  q_rd_addr,
  input  logic [15:0] q_rd_data,
  output logic        q_wr_en,
  output logic [7:0]  q_wr_addr,
  output logic [15:0] q_wr_data,
  output logic [5:0]  cur_state,
  output logic [15:0] episode_cnt
);

  localparam state_t START_S = state_t'(START_STATE);
  localparam state_t GOAL_S  = state_t'(GOAL_STATE);
  localparam logic [7:0] MAX_S = 8'(MAX_STEPS);

  fsm_state_t  fsm;
  logic [2:0]  sub;
  logic [7:0]  step_cnt;
  logic [15:0] num_eps_q;
  logic        rd_vld;
  state_t      s_nxt_q;
  action_t     act_q;
  q_t          q_sa_q;
  logic        goal_q;
  logic        rew_q;

  q_t      row_max;
  action_t row_idx;
  q_t      row_vals [N_ACTIONS];
  logic    row_clr;
  action_t pick;
  state_t  s_nxt;

  assign row_clr = (fsm == S_IDLE)
    || (fsm == S_MOVE) || (fsm == S_CHK);

  q_row_max u_row (
    .clk     (clk),
    .rst     (rst),
    .clear   (row_clr),
    .valid   (rd_vld),
    .value   (q_t'(q_rd_data)),
    .max_val (row_max),
    .max_idx (row_idx),
    .vals    (row_vals)
  );

`ifdef EPSILON_GREEDY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr <= 16'hACE1;
    else
      lfsr <= {1'b0, lfsr[15:1]}
        ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign pick = (lfsr[3:0] == 4'd0)
    ? action_t'(lfsr[5:4]) : row_idx;
`else
  assign pick = row_idx;
`endif

  assign s_nxt = step_state(cur_state, act_q);

  logic signed [17:0] rew;
  logic signed [17:0] max_nxt;
  logic signed [17:0] max_disc;
  logic signed [17:0] q_sa_x;
  logic signed [17:0] td;
  logic signed [18:0] q_sum;
  q_t                 q_new;

  assign rew      = rew_q ? 18'(REWARD) : 18'sd0;
  assign max_nxt  = goal_q ? 18'sd0 : 18'(row_max);
  assign max_disc = max_nxt >>> GAMMA_SHIFT;
  assign q_sa_x   = 18'(q_sa_q);
  assign td       = rew + max_nxt - max_disc - q_sa_x;
  assign q_sum    = 19'(q_sa_q)
    + 19'(td >>> ALPHA_SHIFT);

  always_comb begin
    if (q_sum > 19'sd32767)
      q_new = 16'sh7FFF;
    else if (q_sum < -19'sd32768)
      q_new = 16'sh8000;
    else
      q_new = q_sum[15:0];
  end

  logic [7:0]  step_nxt;
  logic [15:0] ep_nxt;
  logic        ep_end;

  assign step_nxt = step_cnt + 8'd1;
  assign ep_nxt   = episode_cnt + 16'd1;
  assign ep_end   = goal_q || (step_nxt == MAX_S);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= S_IDLE;
      sub         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      q_rd_en     <= 1'b0;
      q_rd_addr   <= '0;
      q_wr_en     <= 1'b0;
      q_wr_addr   <= '0;
      q_wr_data   <= '0;
      cur_state   <= START_S;
      episode_cnt <= '0;
      num_eps_q   <= '0;
      step_cnt    <= '0;
      rd_vld      <= 1'b0;
      s_nxt_q     <= '0;
      act_q       <= ACT_DOWN;
      q_sa_q      <= '0;
      goal_q      <= 1'b0;
      rew_q       <= 1'b0;
    end else begin
      done    <= 1'b0;
      q_wr_en <= 1'b0;
      rd_vld  <= q_rd_en;
      unique case (fsm)
        S_IDLE: begin
          if (start) begin
            episode_cnt <= '0;
            num_eps_q   <= num_episodes;
            cur_state   <= START_S;
            step_cnt    <= '0;
            if (num_episodes == 16'd0) begin
              done <= 1'b1;
            end else begin
              busy      <= 1'b1;
              fsm       <= S_RD_CUR;
              q_rd_en   <= 1'b1;
              q_rd_addr <= {START_S, 2'd0};
              sub       <= '0;
            end
          end
        end
        S_RD_CUR: begin
          sub <= sub + 3'd1;
          if (sub == 3'd3) begin
            q_rd_en <= 1'b0;
            fsm     <= S_SEL;
          end else begin
            q_rd_addr <= {cur_state, sub[1:0] + 2'd1};
          end
        end
        S_SEL: begin
          act_q  <= pick;
          q_sa_q <= row_vals[pick];
          fsm    <= S_MOVE;
        end
        S_MOVE: begin
          s_nxt_q <= s_nxt;
          goal_q  <= (s_nxt == GOAL_S);
          rew_q   <= (s_nxt == GOAL_S)
            && (cur_state != GOAL_S);
          if (s_nxt == GOAL_S) begin
            fsm <= S_UPD;
          end else begin
            fsm       <= S_RD_NXT;
            q_rd_en   <= 1'b1;
            q_rd_addr <= {s_nxt, 2'd0};
            sub       <= '0;
          end
        end
        // One extra cycle here lets the last read land before UPD.
        S_RD_NXT: begin
          sub <= sub + 3'd1;
          if (sub < 3'd3)
            q_rd_addr <= {s_nxt_q, sub[1:0] + 2'd1};
          else
            q_rd_en <= 1'b0;
          if (sub == 3'd4)
            fsm <= S_UPD;
        end
        S_UPD: begin
          q_wr_en   <= 1'b1;
          q_wr_addr <= {cur_state, act_q};
          q_wr_data <= q_new;
          fsm       <= S_CHK;
        end
        S_CHK: begin
          if (ep_end) begin
            episode_cnt <= ep_nxt;
            cur_state   <= START_S;
            step_cnt    <= '0;
            if (ep_nxt == num_eps_q) begin
              done <= 1'b1;
              busy <= 1'b0;
              fsm  <= S_IDLE;
            end else begin
              fsm       <= S_RD_CUR;
              q_rd_en   <= 1'b1;
              q_rd_addr <= {START_S, 2'd0};
              sub       <= '0;
            end
          end else begin
            cur_state <= s_nxt_q;
            step_cnt  <= step_nxt;
            fsm       <= S_RD_CUR;
            q_rd_en   <= 1'b1;
            q_rd_addr <= {s_nxt_q, 2'd0};
            sub       <= '0;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule
